// File: rtl/ysyx_23060251_imm_pkg.sv
// rtl/ysyx_23060251_imm_pkg.sv - select indices, field widths and helpers shared by immediate generation
package ysyx_23060251_imm_pkg;

  localparam int SEL_I  = 0;
  localparam int SEL_S  = 1;
  localparam int SEL_B  = 2;
  localparam int SEL_U  = 3;
  localparam int SEL_J  = 4;
  localparam int SEL_Z  = 5;
  localparam int SEL_CI = 6;
  localparam int SEL_CB = 7;
  localparam int SEL_CJ = 8;

  localparam int NSEL_BASE = 6;
  localparam int NSEL_RVC  = 9;

  localparam int W_I  = 12;
  localparam int W_S  = 12;
  localparam int W_B  = 13;
  localparam int W_U  = 32;
  localparam int W_J  = 21;
  localparam int W_Z  = 5;
  localparam int W_CI = 6;
  localparam int W_CB = 9;
  localparam int W_CJ = 12;

  localparam int XLEN_LEGAL_LO = 32;
  localparam int XLEN_LEGAL_HI = 64;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == XLEN_LEGAL_LO) || (xlen == XLEN_LEGAL_HI);
  endfunction

  // Sign-extend a w-bit field held right-aligned (upper bits zero) in 32 bits.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = 32'(1) << (w - 1);
    return (v ^ m) - m;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate extraction: instruction + one-hot select -> extended immediate
module imm_extract
  import ysyx_23060251_imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int HAS_RVC = 0,
  localparam int NSEL   = (HAS_RVC != 0) ? NSEL_RVC : NSEL_BASE
) (
  input  logic [31:0]      inst,
  input  logic [NSEL-1:0]  sel,
  output logic [XLEN-1:0]  imm,
  output logic             err
);

  logic [NSEL_RVC-1:0] sel_full;
  logic [31:0]         cand [NSEL_RVC];
  logic [31:0]         imm32;
  logic                unused_quadrant;

  // Without RVC the compressed select bits read as zero, so those candidates never contribute.
  assign sel_full        = NSEL_RVC'(sel);
  assign unused_quadrant = ^inst[1:0];

  assign cand[SEL_I]  = sext32({20'b0, inst[31:20]}, W_I);
  assign cand[SEL_S]  = sext32({20'b0, inst[31:25], inst[11:7]}, W_S);
  assign cand[SEL_B]  = sext32({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, W_B);
  assign cand[SEL_U]  = sext32({inst[31:12], 12'b0}, W_U);
  assign cand[SEL_J]  = sext32({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, W_J);
  assign cand[SEL_Z]  = {27'b0, inst[19:15]};
  assign cand[SEL_CI] = sext32({26'b0, inst[12], inst[6:2]}, W_CI);
  assign cand[SEL_CB] = sext32({23'b0, inst[12], inst[6:5], inst[2], inst[11:10],
                                inst[4:3], 1'b0}, W_CB);
  assign cand[SEL_CJ] = sext32({20'b0, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                                inst[2], inst[11], inst[5:3], 1'b0}, W_CJ);

  // OR-merge keeps multi-hot selects deterministic; bit 31 extension distributes over the OR.
  always_comb begin
    imm32 = '0;
    for (int i = 0; i < NSEL_RVC; i++) begin
      if (sel_full[i]) imm32 = imm32 | cand[i];
    end
    imm = XLEN'($signed(imm32));
    err = |(sel_full & (sel_full - NSEL_RVC'(1)));
  end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate-generation stage with output register plus one skid entry
module imm_gen_stage
  import ysyx_23060251_imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int HAS_RVC = 0,
  parameter int TAG_W   = 32,
  localparam int NSEL   = (HAS_RVC != 0) ? NSEL_RVC : NSEL_BASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [NSEL-1:0]  imm_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             sel_err_o
);

  buf_state_e       state, state_next;
  logic [XLEN-1:0]  ext_imm, main_imm, skid_imm;
  logic             ext_err, main_err, skid_err;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             accept, emit;
  logic             load_main, load_skid, main_from_skid;

  imm_extract #(
    .XLEN    (XLEN),
    .HAS_RVC (HAS_RVC)
  ) u_extract (
    .inst (inst_i),
    .sel  (imm_sel_i),
    .imm  (ext_imm),
    .err  (ext_err)
  );

  // Ready decodes only the state register, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (state != BUF_FULL);
  assign out_valid_o = (state != BUF_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign emit        = out_valid_o & out_ready_i;

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      BUF_EMPTY: begin
        if (accept) begin
          state_next = BUF_ONE;
          load_main  = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && emit) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_next = BUF_FULL;
          load_skid  = 1'b1;
        end else if (emit) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (emit) begin
          state_next     = BUF_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BUF_EMPTY;
      main_imm <= '0;
      main_tag <= '0;
      main_err <= 1'b0;
      skid_imm <= '0;
      skid_tag <= '0;
      skid_err <= 1'b0;
    end else begin
      state <= state_next;
      if (load_main) begin
        main_imm <= main_from_skid ? skid_imm : ext_imm;
        main_tag <= main_from_skid ? skid_tag : tag_i;
        main_err <= main_from_skid ? skid_err : ext_err;
      end
      if (load_skid) begin
        skid_imm <= ext_imm;
        skid_tag <= tag_i;
        skid_err <= ext_err;
      end
    end
  end

  assign imm_o     = main_imm;
  assign tag_o     = main_tag;
  assign sel_err_o = main_err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - randomized scoreboard bench for imm_gen_stage (XLEN=64+RVC and XLEN=32 instances)
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] tag = '0;
  logic [8:0]  sel = '0;

  logic        rdy64, ov64, err64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic        rdy32, ov32, err32;
  logic [31:0] imm32;
  logic [31:0] tago32;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } beat_t;

  beat_t q64[$];
  beat_t q32[$];
  beat_t hb64, hb32;
  bit    h64 = 0, h32 = 0;
  bit    acc64 = 0;
  int    n_cmp = 0, n_bad = 0;
  int    n_acc;

  // Compressed offset scatter tables: instruction bit -> offset bit.
  int cb_src[8]  = '{12, 11, 10, 6, 5, 4, 3, 2};
  int cb_dst[8]  = '{8, 4, 3, 7, 6, 2, 1, 5};
  int cj_src[11] = '{12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2};
  int cj_dst[11] = '{11, 4, 9, 8, 10, 6, 7, 3, 2, 1, 5};

  imm_gen_stage #(.XLEN(64), .HAS_RVC(1), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .inst_i(inst), .imm_sel_i(sel), .tag_i(tag),
    .out_valid_o(ov64), .out_ready_i(out_ready),
    .imm_o(imm64), .tag_o(tag64), .sel_err_o(err64)
  );

  imm_gen_stage #(.XLEN(32), .HAS_RVC(0), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .inst_i(inst), .imm_sel_i(sel[5:0]), .tag_i(tag),
    .out_valid_o(ov32), .out_ready_i(out_ready),
    .imm_o(imm32), .tag_o(tago32), .sel_err_o(err32)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic longint sx(longint v, int w);
    if (((v >> (w - 1)) & 1) != 0) return v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [63:0] model_imm(logic [31:0] in, logic [8:0] s, int xl);
    longint r, f;
    r = 0;
    if (s[0]) r |= sx(longint'(in[31:20]), 12);
    if (s[1]) r |= sx(longint'({in[31:25], in[11:7]}), 12);
    if (s[2]) r |= sx(longint'({in[31], in[7], in[30:25], in[11:8], 1'b0}), 13);
    if (s[3]) r |= sx(longint'(in[31:12]) * 4096, 32);
    if (s[4]) r |= sx(longint'({in[31], in[19:12], in[20], in[30:21], 1'b0}), 21);
    if (s[5]) r |= longint'(in[19:15]);
    if (s[6]) r |= sx(longint'({in[12], in[6:2]}), 6);
    if (s[7]) begin
      f = 0;
      for (int k = 0; k < 8; k++) f += longint'(in[cb_src[k]]) << cb_dst[k];
      r |= sx(f, 9);
    end
    if (s[8]) begin
      f = 0;
      for (int k = 0; k < 11; k++) f += longint'(in[cj_src[k]]) << cj_dst[k];
      r |= sx(f, 12);
    end
    if (xl == 32) r &= 64'hFFFF_FFFF;
    return r;
  endfunction

  // Called in the low phase with inputs set; scores this cycle's handshakes, then advances one clock.
  task automatic tick();
    beat_t e;
    logic [8:0] s32;
    s32 = sel & 9'h03F;
    acc64 = 0;
    if (!rst) begin
      chk("rdy64", rdy64, q64.size() < 2);
      chk("vld64", ov64, q64.size() != 0);
      if (h64) begin
        chk("hold_imm64", imm64, hb64.imm);
        chk("hold_tag64", tag64, hb64.tag);
      end
      if (ov64 && out_ready && q64.size() != 0) begin
        e = q64.pop_front();
        chk("imm64", imm64, e.imm);
        chk("tag64", tag64, e.tag);
        chk("err64", err64, e.err);
      end
      h64  = ov64 && !out_ready;
      hb64 = '{imm64, tag64, err64};
      acc64 = in_valid && rdy64;
      if (acc64) q64.push_back('{model_imm(inst, sel, 64), tag, $countones(sel) > 1});

      chk("rdy32", rdy32, q32.size() < 2);
      chk("vld32", ov32, q32.size() != 0);
      if (h32) begin
        chk("hold_imm32", imm32, hb32.imm);
        chk("hold_tag32", tago32, hb32.tag);
      end
      if (ov32 && out_ready && q32.size() != 0) begin
        e = q32.pop_front();
        chk("imm32", imm32, e.imm);
        chk("tag32", tago32, e.tag);
        chk("err32", err32, e.err);
      end
      h32  = ov32 && !out_ready;
      hb32 = '{64'(imm32), tago32, err32};
      if (in_valid && rdy32) q32.push_back('{model_imm(inst, s32, 32), tag, $countones(s32) > 1});
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      q64.delete();
      q32.delete();
      h64 = 0;
      h32 = 0;
    end
  endtask

  task automatic direct(string nm, logic [31:0] i, logic [8:0] s, logic [63:0] e64,
                        logic e_err, logic [31:0] e32);
    out_ready = 1;
    in_valid  = 1;
    inst      = i;
    sel       = s;
    tag       = tag + 1;
    tick();
    in_valid = 0;
    chk({nm, "_vld"}, ov64, 1);
    chk({nm, "_imm64"}, imm64, e64);
    chk({nm, "_err64"}, err64, e_err);
    chk({nm, "_imm32"}, imm32, e32);
    tick();
  endtask

  task automatic new_beat();
    int mode;
    inst = $urandom;
    tag  = $urandom;
    mode = $urandom_range(0, 9);
    if (mode == 0) sel = '0;
    else if (mode <= 2) sel = 9'($urandom_range(0, 511));
    else sel = 9'(1) << $urandom_range(0, 8);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_vld64", ov64, 0);
    chk("rst_rdy64", rdy64, 1);
    chk("rst_imm64", imm64, 0);
    chk("rst_tag64", tag64, 0);
    chk("rst_err64", err64, 0);
    chk("rst_rdy32", rdy32, 1);

    direct("i",     32'hFFF00093, 9'h001, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'hFFFF_FFFF);
    direct("u",     32'h80000037, 9'h008, 64'hFFFF_FFFF_8000_0000, 0, 32'h8000_0000);
    direct("j",     32'hFFDFF06F, 9'h010, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hFFFF_FFFC);
    direct("cj",    32'h0000BFFD, 9'h100, 64'hFFFF_FFFF_FFFF_FFFE, 0, 32'h0);
    direct("ci",    32'h000010FD, 9'h040, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0);
    direct("z",     32'h000F8000, 9'h020, 64'd31, 0, 32'd31);
    direct("multi", 32'h00100F93, 9'h003, 64'h1F, 1, 32'h1F);
    direct("zero",  32'hFFFFFFFF, 9'h000, 64'h0, 0, 32'h0);

    // Back-pressure: three beats against a stalled sink.
    out_ready = 0;
    in_valid  = 1;
    sel       = 9'h001;
    inst      = $urandom;
    tag       = 1;
    n_acc     = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (acc64) begin
        n_acc++;
        tag  = tag + 1;
        inst = $urandom;
      end
    end
    chk("bp_accepts", n_acc, 2);
    chk("bp_ready_low", rdy64, 0);
    chk("bp_tag_held", tag, 3);
    out_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      chk("bp_vld", ov64, 1);
      chk("bp_order", tag64, k);
      tick();
      if (acc64) in_valid = 0;
    end
    chk("bp_drained", ov64, 0);

    // Reset while FULL.
    out_ready = 0;
    in_valid  = 1;
    sel       = 9'h008;
    tag       = 10;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (acc64) tag = tag + 1;
    end
    chk("full_ready", rdy64, 0);
    rst      = 1;
    in_valid = 0;
    tick();
    rst = 0;
    chk("rf_vld64", ov64, 0);
    chk("rf_rdy64", rdy64, 1);
    chk("rf_imm64", imm64, 0);
    chk("rf_tag64", tag64, 0);
    chk("rf_vld32", ov32, 0);
    chk("rf_imm32", imm32, 0);
    direct("post_rst", 32'h00500093, 9'h001, 64'd5, 0, 32'd5);

    // Random traffic; an unaccepted beat is held until taken.
    in_valid = 0;
    new_beat();
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !acc64 && c > 0)) in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc64) new_beat();
    end
    in_valid  = 0;
    out_ready = 1;
    repeat (4) tick();
    chk("drain64", q64.size(), 0);
    chk("drain32", q32.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
